// File: rtl/uart_tx_rs485_if.sv
// Write-side handshake between a producer and the RS-485 UART transmitter.
// Signal names are seen from the transmitter's side.
interface uart_tx_rs485_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 i_tx_valid;
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 o_tx_ready;

  modport master (output i_tx_valid, output i_tx_data, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_data, output o_tx_ready);
endinterface

// File: rtl/uart_tx_rs485.sv
// Buffered UART transmitter for half-duplex RS-485: FIFO, configurable framing,
// driver-enable lead/tail guard times and line-break generation.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} par_e;
endpackage

module uart_tx_rs485 #(
  parameter int unsigned    F_CLK_HZ      = 48_000_000,
  parameter int unsigned    BAUD          = 115_200,
  parameter int unsigned    OVERS         = 16,
  parameter int unsigned    DATA_BITS     = 8,
  parameter int unsigned    STOP_BITS     = 1,
  parameter uart_pkg::par_e PAR           = uart_pkg::PAR_NONE,
  parameter int unsigned    FIFO_DEPTH    = 16,
  parameter int unsigned    DE_LEAD_TICKS = 16,
  parameter int unsigned    DE_TAIL_TICKS = 16,
  parameter int unsigned    BREAK_BITS    = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_rs485_if.slave                tx_if,
  input  logic                          i_flush,
  input  logic                          i_break,
  output logic                          o_txd,
  output logic                          o_de,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned CNT_MAX_A = (OVERS > DE_LEAD_TICKS) ? OVERS : DE_LEAD_TICKS;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > DE_TAIL_TICKS) ? CNT_MAX_A : DE_TAIL_TICKS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_MAX_A = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BIT_MAX   = (BIT_MAX_A > BREAK_BITS) ? BIT_MAX_A : BREAK_BITS;
  localparam int unsigned BIT_W     = $clog2(BIT_MAX + 1);

  localparam logic [CNT_W-1:0] OV_LAST   = CNT_W'(OVERS - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((DE_LEAD_TICKS == 0) ? 0 : DE_LEAD_TICKS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'((DE_TAIL_TICKS == 0) ? 0 : DE_TAIL_TICKS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] BRK_LAST  = BIT_W'(BREAK_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [32:0]      ACC_INC   = 33'(BAUD * OVERS);
  localparam logic [32:0]      ACC_MOD   = 33'(F_CLK_HZ);

  typedef enum logic [3:0] {
    StIdle, StLead, StStart, StData, StPar, StStop, StTail, StBreak, StMark
  } state_e;

  state_e                 r_state, w_state_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIT_W-1:0]       r_bit;
  logic [32:0]            r_acc, w_sum;
  logic                   w_tick, w_bit_end, w_in_bit;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr, r_rptr;
  logic [LVL_W-1:0]       r_level;
  logic                   w_empty, w_wr, w_pop, w_ready;
  logic [DATA_BITS-1:0]   r_shift, w_shift_d, w_head;
  logic                   r_par, w_par_d;
  logic                   r_break_pend, w_break_clr;
  logic                   r_txd, w_txd_d, r_de, w_de_d;

  // Fractional baud accumulator; tick phase is free-running.
  assign w_sum  = r_acc + ACC_INC;
  assign w_tick = (w_sum >= ACC_MOD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_tick ? (w_sum - ACC_MOD) : w_sum;
  end

  assign w_empty          = (r_level == '0);
  assign w_ready          = (r_level < LVL_FULL) && !i_flush;
  assign tx_if.o_tx_ready = w_ready;
  assign w_wr             = tx_if.i_tx_valid && w_ready;
  assign w_pop            = (w_state_d == StStart) && (r_state != StStart);
  assign w_head           = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= tx_if.i_tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_break_pend <= 1'b0;
    else if (i_break)     r_break_pend <= 1'b1;
    else if (w_break_clr) r_break_pend <= 1'b0;
  end

  assign w_in_bit  = r_state inside {StStart, StData, StPar, StStop, StBreak, StMark};
  assign w_bit_end = w_tick && w_in_bit && (r_cnt == OV_LAST);

  // State register: sub-counters restart on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_de    <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_txd   <= w_txd_d;
      r_de    <= w_de_d;
      r_shift <= w_shift_d;
      r_par   <= w_par_d;
      if (w_state_d != r_state) begin
        r_cnt <= '0;
        r_bit <= '0;
      end else if (w_tick && (r_state != StIdle)) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          r_bit <= r_bit + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Next state. Queued words always go before a pending break.
  always_comb begin
    w_state_d   = r_state;
    w_break_clr = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty || r_break_pend) begin
          if (DE_LEAD_TICKS == 0) w_state_d = !w_empty ? StStart : StBreak;
          else                    w_state_d = StLead;
        end
      end
      StLead: begin
        if (w_tick && (r_cnt == LEAD_LAST)) begin
          if (!w_empty)          w_state_d = StStart;
          else if (r_break_pend) w_state_d = StBreak;
          else                   w_state_d = StTail;
        end
      end
      StStart: if (w_bit_end) w_state_d = StData;
      StData: begin
        if (w_bit_end && (r_bit == DATA_LAST)) begin
          w_state_d = (PAR != uart_pkg::PAR_NONE) ? StPar : StStop;
        end
      end
      StPar: if (w_bit_end) w_state_d = StStop;
      StStop: begin
        if (w_bit_end && (r_bit == STOP_LAST)) begin
          if (!w_empty)          w_state_d = StStart;
          else if (r_break_pend) w_state_d = StBreak;
          else                   w_state_d = StTail;
        end
      end
      StTail: begin
        if (w_tick) begin
          if (!w_empty)                 w_state_d = StStart;
          else if (r_break_pend)        w_state_d = StBreak;
          else if (r_cnt == TAIL_LAST)  w_state_d = StIdle;
        end
      end
      StBreak: begin
        if (w_bit_end && (r_bit == BRK_LAST)) begin
          w_state_d   = StMark;
          w_break_clr = 1'b1;
        end
      end
      StMark: if (w_bit_end) w_state_d = StTail;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so o_txd/o_de register in step with it.
  always_comb begin
    w_shift_d = r_shift;
    w_par_d   = r_par;
    if (w_pop) begin
      w_shift_d = w_head;
      w_par_d   = (PAR == uart_pkg::PAR_ODD) ? ~^w_head : ^w_head;
    end else if ((r_state == StData) && w_bit_end) begin
      w_shift_d = r_shift >> 1;
    end
    w_de_d  = (w_state_d != StIdle);
    w_txd_d = 1'b1;
    unique case (w_state_d)
      StStart, StBreak: w_txd_d = 1'b0;
      StData:           w_txd_d = w_shift_d[0];
      StPar:            w_txd_d = w_par_d;
      default:          w_txd_d = 1'b1;
    endcase
  end

  assign o_txd        = r_txd;
  assign o_de         = r_de;
  assign o_busy       = (r_state != StIdle) || !w_empty || r_break_pend;
  assign o_fifo_level = r_level;

endmodule

// File: doc/uart_tx_rs485.md
# uart_tx_rs485

Buffered, parametrised UART transmitter for the half-duplex RS-485 links used by the JVS debugger. It accepts words through a valid/ready port into an internal FIFO and serialises them with configurable word length, parity and stop bits. It drives the transceiver's driver-enable pin with programmable lead and tail guard times. It can also emit a line break on request.

## Interface
- F_CLK_HZ, 48_000_000: system clock frequency.
- BAUD, 115_200: bit rate.
- OVERS, 16: oversample ticks per bit (≥2).
- DATA_BITS, 8: word length, 5..9, sent LSB first.
- STOP_BITS, 1: stop bits, 1 or 2.
- PAR, uart_pkg::PAR_NONE: parity mode, one of PAR_NONE, PAR_EVEN or PAR_ODD.
- FIFO_DEPTH, 16: FIFO entries, power of two, ≥2.
- DE_LEAD_TICKS, 16: ticks o_de is high before the first start bit (0 allowed).
- DE_TAIL_TICKS, 16: ticks o_de stays high after the last stop bit (0 allowed).
- BREAK_BITS, 13: bit times the line is held low for a break.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock domain; reset is asynchronous and active-low.
- i_tx_valid  in  1  write request.
- i_tx_data  in  DATA_BITS  word to send.
- o_tx_ready  out  1  FIFO can accept a word.
- i_flush  in  1  single-cycle; discards all queued words.
- i_break  in  1  single-cycle; requests a break.
- o_txd  out  1  serial line, idle high.
- o_de  out  1  RS-485 driver enable.
- o_busy  out  1  any queued word, pending break, or non-idle state.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Tick generator: 33-bit free-running accumulator. Each cycle it adds BAUD*OVERS. When the sum is ≥F_CLK_HZ, it subtracts F_CLK_HZ and asserts `tick` for one cycle. The accumulator resets to 0.
- FIFO:
  - o_tx_ready = (level<FIFO_DEPTH) && !i_flush.
  - A write occurs when i_tx_valid && o_tx_ready.
  - A pop occurs on entry to S_START, loading the shift register and computing parity.
  - A write and a pop in the same cycle leave the level unchanged.
  - There is no bypass when the FIFO is full.
  - i_flush zeroes the level on that edge and takes priority over a simultaneous write. The frame in flight still completes.
- Parity: PAR_EVEN bit = ^data; PAR_ODD bit = ~^data. Computed over DATA_BITS only.
- A break request is latched into break_pend until it is serviced. It is serviced only when the FIFO is empty, so queued words go first.
- All bit timing is measured in ticks by a sub-counter that is cleared on every state entry. A bit lasts exactly OVERS ticks.

States:
- S_IDLE: o_txd=1, o_de=0.
  - FIFO non-empty or break_pend → o_de←1.
  - Goes to S_LEAD, or directly to S_START/S_BREAK when DE_LEAD_TICKS=0.
- S_LEAD: o_txd=1. After DE_LEAD_TICKS ticks → S_START if FIFO non-empty, else S_BREAK.
- S_START: o_txd=0 for OVERS ticks → S_DATA.
- S_DATA: DATA_BITS bits, LSB first → S_PAR if PAR≠PAR_NONE, else S_STOP.
- S_PAR: parity bit for one bit time → S_STOP.
- S_STOP: o_txd=1 for STOP_BITS bit times. Then:
  - FIFO non-empty → S_START (no gap, o_de stays high).
  - break_pend → S_BREAK.
  - otherwise → S_TAIL.
- S_TAIL: o_txd=1, o_de=1. Per tick:
  - FIFO non-empty → S_START.
  - break_pend → S_BREAK.
  - After DE_TAIL_TICKS ticks → S_IDLE with o_de←0. DE_TAIL_TICKS=0 exits on the first tick.
- S_BREAK: o_txd=0 for BREAK_BITS bit times, clears break_pend, then o_txd=1 for one bit time (mark after break) → S_TAIL.
- o_busy = (state≠S_IDLE) || level≠0 || break_pend.

## Timing
- Reset (asynchronous, immediate):
  - o_txd=1, o_de=0, o_busy=0.
  - o_fifo_level=0, o_tx_ready=1.
  - break_pend=0, state S_IDLE.
  - Writes while rst_n=0 are ignored.
  - A reset mid-frame truncates the frame with no glitch low on o_txd.
- o_txd and o_de are registered outputs. o_tx_ready and o_busy are combinational from registers.
- Accepted write on edge N into an idle, empty block: level=1 after N. o_de=1 and state leaves S_IDLE after edge N+1.
- The first state duration may be shortened by less than one tick period, because the tick phase is free-running. Every later bit is exact.
- Consecutive frames have no idle time between the last stop bit and the next start bit.

## Test plan
Sim config for all scenarios: F_CLK_HZ=1_600_000, BAUD=100_000, OVERS=16, so tick fires every cycle and one bit = 16 cycles.

1. 8N1, write 0xA5 → o_de high, then:
   - o_txd high 16 cycles (lead);
   - low 16 (start);
   - bits 1,0,1,0,0,1,0,1 at 16 cycles each;
   - high 16 (stop);
   - o_de drops 16 cycles later; o_busy falls with o_de.
2. Write 0x01,0x02,0x03,0x04 back-to-back → four contiguous 160-cycle frames, o_de continuously high, a single lead and a single tail, level goes 4→0.
3. While the first frame is sending, write until refused → level reaches 16 and o_tx_ready=0. The 17th word is not written until a pop. i_flush then sets level=0, the current frame completes, and the line goes idle.
4. PAR_EVEN, STOP_BITS=2, word 0x07 → parity bit 1 followed by 32 high cycles. With PAR_ODD the parity bit is 0. DATA_BITS=9 word 0x1FF → nine 1-bits.
5. i_break pulse with the FIFO empty → 16 lead cycles, o_txd low 208 cycles, high 16, tail 16, o_de low. A break requested while 2 words are queued is sent after both frames.
6. Deassert rst_n mid data bit (o_txd=0) → o_txd=1 and o_de=0 in the same cycle, level=0. After release, the block is idle until the next write.
